// File: rtl/jtframe_rom_pkg.sv
// Shared helpers for the block-RAM ROM: programming-window size and
// byte-lane mapping from the active-low prog_mask.
package jtframe_rom_pkg;

    // 16-bit programming words covered by a ROM of 2^aw words of dw bits
    function automatic int words(input int dw, input int aw);
        if (dw == 8)  return 1 << (aw - 1);
        if (dw == 16) return 1 << aw;
        return 1 << (aw + 1);
    endfunction

    // 8-bit ROMs store a single lane: the low byte wins when both are enabled
    function automatic logic byte_lane(input logic [1:0] mask);
        return mask[0];
    endfunction

    // 32-bit ROMs: even programming words fill the low half
    function automatic logic [3:0] half_be(input logic [1:0] mask, input logic odd);
        return {~mask & {2{odd}}, ~mask & {2{~odd}}};
    endfunction

endpackage

// File: rtl/jtframe_bram_bewr.sv
// Simple dual-port RAM with byte-enabled write port and registered read port.
// Latency: 1 cycle read; same-address read/write returns the old word.
// Backpressure: none, a read and a write are accepted every cycle.
module jtframe_bram_bewr #(
    parameter int DW = 16,
    parameter int AW = 10
) (
    input  logic            clk_i,
    input  logic [DW/8-1:0] we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [DW-1:0]   wdata_i,
    input  logic [AW-1:0]   raddr_i,
    output logic [DW-1:0]   rdata_o
);
    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < DW/8; b++) begin
            if (we_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/jtframe_bram_rom_mc.sv
// Multi-channel ROM in block RAM, loaded from the byte-wide download bus.
// Latency: hit gives rd_ok combinationally; a miss gives rd_ok 2 cycles after grant.
// Backpressure: channels wait for a round-robin grant, at most CH cycles.
module jtframe_bram_rom_mc
    import jtframe_rom_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 10,
    parameter int CH = 2,
`ifdef JTFRAME_SDRAM_LARGE
    parameter int PW = 25,
`else
    parameter int PW = 24,
`endif
    parameter int OFFSET = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           downloading,
    input  logic [CH-1:0]    rd_cs,
    input  logic [CH*AW-1:0] rd_addr,
    output logic [CH-1:0]    rd_ok,
    output logic [CH*DW-1:0] rd_data,
    input  logic [PW-1:0]  prog_addr,
    input  logic [1:0]     prog_mask,
    input  logic [7:0]     prog_data,
    input  logic           prog_we,
    output logic           loaded
);
    localparam int WORDS = words(DW, AW);
    localparam int NB    = DW / 8;
    localparam int CW    = (CH > 1) ? $clog2(CH) : 1;

    typedef enum logic [1:0] { ST_IDLE, ST_REQ, ST_WAIT } ch_state_t;

    if (DW != 8 && DW != 16 && DW != 32) begin : g_bad_dw
        $error("jtframe_bram_rom_mc: DW must be 8, 16 or 32");
    end
    if (CH < 1 || CH > 8) begin : g_bad_ch
        $error("jtframe_bram_rom_mc: CH must be 1..8");
    end

    logic [PW:0]   aeff;
    logic          in_range;
    logic [AW-1:0] wr_addr;
    logic [NB-1:0] wr_be;
    logic [NB-1:0] ram_we;
    logic [DW-1:0] wr_data;

    // Addresses below OFFSET wrap to large values and fail the same compare
    assign aeff     = {1'b0, prog_addr} - (PW+1)'(OFFSET);
    assign in_range = aeff < (PW+1)'(WORDS);
    assign wr_data  = {NB{prog_data}};
    assign ram_we   = (prog_we && in_range) ? wr_be : '0;

    if (DW == 8) begin : g_wr8
        assign wr_addr = {aeff[AW-2:0], byte_lane(prog_mask)};
        assign wr_be   = ~&prog_mask;
    end else if (DW == 16) begin : g_wr16
        assign wr_addr = aeff[AW-1:0];
        assign wr_be   = ~prog_mask;
    end else begin : g_wr32
        assign wr_addr = aeff[AW:1];
        assign wr_be   = half_be(prog_mask, aeff[0]);
    end

    logic [CH-1:0] req;
    logic [CH-1:0] gnt;
    logic [CW-1:0] ptr_q, ptr_d, gnt_idx;
    logic          gnt_any;
    logic [AW-1:0] rd_sel_addr;
    logic [DW-1:0] ram_dout;
    logic          dl_q, loaded_q;

    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = 0; k < CH; k++) begin
            idx = (int'(ptr_q) + k) % CH;
            if (!gnt_any && req[idx] && !downloading) begin
                gnt_any = 1'b1;
                gnt_idx = CW'(idx);
            end
        end
        if (gnt_any) gnt[gnt_idx] = 1'b1;
        ptr_d = gnt_any ? CW'((int'(gnt_idx) + 1) % CH) : ptr_q;
    end

    assign rd_sel_addr = rd_addr[int'(gnt_idx)*AW +: AW];

    jtframe_bram_bewr #(.DW(DW), .AW(AW)) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .waddr_i (wr_addr),
        .wdata_i (wr_data),
        .raddr_i (rd_sel_addr),
        .rdata_o (ram_dout)
    );

    for (genvar n = 0; n < CH; n++) begin : g_ch
        ch_state_t     st_q, st_d;
        logic          valid_q;
        logic [AW-1:0] caddr_q;
        logic [DW-1:0] data_q;
        logic [AW-1:0] addr;
        logic          hit;

        assign addr                = rd_addr[n*AW +: AW];
        assign hit                 = valid_q && (addr == caddr_q);
        assign req[n]              = (st_q == ST_REQ) || (st_q == ST_IDLE && rd_cs[n] && !hit);
        assign rd_ok[n]            = rd_cs[n] && hit && !downloading;
        assign rd_data[n*DW +: DW] = data_q;

        always_comb begin
            st_d = st_q;
            case (st_q)
                ST_IDLE: if (req[n]) st_d = gnt[n] ? ST_WAIT : ST_REQ;
                ST_REQ:  if (gnt[n]) st_d = ST_WAIT;
                ST_WAIT: st_d = ST_IDLE;
                default: st_d = ST_IDLE;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                st_q    <= ST_IDLE;
                valid_q <= 1'b0;
                caddr_q <= '0;
                data_q  <= '0;
            end else begin
                st_q <= st_d;
                if (gnt[n]) begin
                    caddr_q <= addr;
                    valid_q <= 1'b0;
                end
                // Only one channel is ever in WAIT, so the RAM output is ours
                if (st_q == ST_WAIT) begin
                    data_q  <= ram_dout;
                    valid_q <= 1'b1;
                end
                if (downloading) valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q    <= '0;
            dl_q     <= 1'b0;
            loaded_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            dl_q  <= downloading;
            if (downloading)  loaded_q <= 1'b0;
            else if (dl_q)    loaded_q <= 1'b1;
        end
    end

    assign loaded = loaded_q;

endmodule

// File: tb/tb_jtframe_bram_rom_mc.sv
// Bench for jtframe_bram_rom_mc: a 16-bit 3-channel ROM plus 32-bit and 8-bit
// single-channel ROMs sharing one programming bus, checked against a byte-array model.
module tb_jtframe_bram_rom_mc;

    logic        clk = 1'b0;
    logic        rst, downloading;
    logic [23:0] prog_addr;
    logic [1:0]  prog_mask;
    logic [7:0]  prog_data;
    logic        prog_we;

    logic [2:0]  m_cs, m_ok;
    logic [11:0] m_addr;
    logic [47:0] m_data;
    logic        m_loaded;
    logic        w_cs, w_ok, w_loaded;
    logic [3:0]  w_addr;
    logic [31:0] w_data;
    logic        b_cs, b_ok, b_loaded;
    logic [3:0]  b_addr;
    logic [7:0]  b_data;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    jtframe_bram_rom_mc #(.DW(16), .AW(4), .CH(3), .OFFSET('h10)) u_m (
        .clk(clk), .rst(rst), .downloading(downloading),
        .rd_cs(m_cs), .rd_addr(m_addr), .rd_ok(m_ok), .rd_data(m_data),
        .prog_addr(prog_addr), .prog_mask(prog_mask), .prog_data(prog_data),
        .prog_we(prog_we), .loaded(m_loaded)
    );
    jtframe_bram_rom_mc #(.DW(32), .AW(4), .CH(1), .OFFSET('h40)) u_w (
        .clk(clk), .rst(rst), .downloading(downloading),
        .rd_cs(w_cs), .rd_addr(w_addr), .rd_ok(w_ok), .rd_data(w_data),
        .prog_addr(prog_addr), .prog_mask(prog_mask), .prog_data(prog_data),
        .prog_we(prog_we), .loaded(w_loaded)
    );
    jtframe_bram_rom_mc #(.DW(8), .AW(4), .CH(1), .OFFSET('h80)) u_b (
        .clk(clk), .rst(rst), .downloading(downloading),
        .rd_cs(b_cs), .rd_addr(b_addr), .rd_ok(b_ok), .rd_data(b_data),
        .prog_addr(prog_addr), .prog_mask(prog_mask), .prog_data(prog_data),
        .prog_we(prog_we), .loaded(b_loaded)
    );

    // Reference: every ROM is a plain byte array addressed by 2*(prog_addr-OFFSET)+lane
    logic [7:0] m_mem [32];
    logic [7:0] w_mem [64];
    logic [7:0] b_mem [16];

    typedef struct packed { logic [31:0] addr; logic [1:0] mask; logic [7:0] data; } wr_vec_t;
    typedef struct packed { logic [31:0] who; logic [31:0] addr; logic [31:0] exp; } rd_vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic model_wr(input int addr, input logic [1:0] mask, input logic [7:0] data);
        int a;
        a = addr - 'h10;
        if (a >= 0 && a < 16)
            for (int l = 0; l < 2; l++) if (!mask[l]) m_mem[a*2+l] = data;
        a = addr - 'h40;
        if (a >= 0 && a < 32)
            for (int l = 0; l < 2; l++) if (!mask[l]) w_mem[a*2+l] = data;
        a = addr - 'h80;
        if (a >= 0 && a < 8 && mask != 2'b11) b_mem[a*2 + (mask[0] ? 1 : 0)] = data;
    endtask

    function automatic logic [31:0] model_rd(input int who, input int addr);
        case (who)
            0, 1, 2: return {16'h0, m_mem[addr*2+1], m_mem[addr*2]};
            3:       return {w_mem[addr*4+3], w_mem[addr*4+2], w_mem[addr*4+1], w_mem[addr*4]};
            default: return {24'h0, b_mem[addr]};
        endcase
    endfunction

    task automatic prog_wr(input int addr, input logic [1:0] mask, input logic [7:0] data);
        nxt();
        prog_addr = 24'(addr);
        prog_mask = mask;
        prog_data = data;
        prog_we   = 1'b1;
        model_wr(addr, mask, data);
        nxt();
        prog_we   = 1'b0;
    endtask

    task automatic set_rd(input int who, input logic cs, input int addr);
        case (who)
            0, 1, 2: begin m_cs[who] = cs; m_addr[who*4 +: 4] = addr[3:0]; end
            3:       begin w_cs = cs; w_addr = addr[3:0]; end
            default: begin b_cs = cs; b_addr = addr[3:0]; end
        endcase
    endtask

    function automatic logic get_ok(input int who);
        case (who)
            0, 1, 2: return m_ok[who];
            3:       return w_ok;
            default: return b_ok;
        endcase
    endfunction

    function automatic logic [31:0] get_data(input int who);
        case (who)
            0, 1, 2: return {16'h0, m_data[who*16 +: 16]};
            3:       return w_data;
            default: return {24'h0, b_data};
        endcase
    endfunction

    // lat = cycles from rd_cs rising to rd_ok (-1 if it never came)
    task automatic do_read(input int who, input int addr, input bit keep,
                           output int lat, output logic [31:0] d);
        lat = -1;
        d   = '0;
        nxt();
        set_rd(who, 1'b1, addr);
        for (int c = 0; c < 24 && lat < 0; c++) begin
            if (c > 0) nxt();
            #4;
            if (get_ok(who)) begin
                lat = c;
                d   = get_data(who);
            end
        end
        if (!keep) begin
            nxt();
            set_rd(who, 1'b0, addr);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        wr_vec_t     wq[$];
        rd_vec_t     rq[$];
        int          lat;
        logic [31:0] d;
        int          first [3];
        logic [31:0] fdat  [3];

        rst = 1'b1; downloading = 1'b0;
        prog_addr = '0; prog_mask = 2'b11; prog_data = '0; prog_we = 1'b0;
        m_cs = '0; m_addr = '0; w_cs = 1'b0; w_addr = '0; b_cs = 1'b0; b_addr = '0;
        repeat (3) nxt();
        #4;
        chk("rst_m_ok", m_ok, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_w_data", w_data, 0);
        chk("rst_b_data", b_data, 0);
        chk("rst_loaded", {m_loaded, w_loaded, b_loaded}, 0);
        nxt();
        rst = 1'b0;

        // Download 1: random fill of every byte, then the directed writes
        nxt();
        downloading = 1'b1;
        for (int a = 'h10; a < 'h20; a++) begin
            prog_wr(a, 2'b10, 8'($urandom)); prog_wr(a, 2'b01, 8'($urandom));
        end
        for (int a = 'h40; a < 'h60; a++) begin
            prog_wr(a, 2'b10, 8'($urandom)); prog_wr(a, 2'b01, 8'($urandom));
        end
        for (int a = 'h80; a < 'h88; a++) begin
            prog_wr(a, 2'b10, 8'($urandom)); prog_wr(a, 2'b01, 8'($urandom));
        end

        wq.push_back('{32'h13, 2'b10, 8'h34});
        wq.push_back('{32'h13, 2'b01, 8'h12});
        wq.push_back('{32'h10, 2'b00, 8'hEF});
        wq.push_back('{32'h1F, 2'b10, 8'hFE});
        wq.push_back('{32'h1F, 2'b01, 8'hCA});
        wq.push_back('{32'h20, 2'b00, 8'h55});
        wq.push_back('{32'h0F, 2'b00, 8'h77});
        wq.push_back('{32'h12, 2'b00, 8'h66});
        wq.push_back('{32'h12, 2'b11, 8'h99});
        wq.push_back('{32'h40, 2'b10, 8'hAA});
        wq.push_back('{32'h40, 2'b01, 8'hBB});
        wq.push_back('{32'h41, 2'b10, 8'hCC});
        wq.push_back('{32'h41, 2'b01, 8'hDD});
        wq.push_back('{32'h60, 2'b00, 8'h11});
        wq.push_back('{32'h80, 2'b10, 8'h42});
        wq.push_back('{32'h82, 2'b01, 8'h5A});
        wq.push_back('{32'h82, 2'b10, 8'hA5});
        wq.push_back('{32'h83, 2'b00, 8'h3C});
        wq.push_back('{32'h88, 2'b10, 8'h77});
        for (int i = 0; i < wq.size(); i++) prog_wr(int'(wq[i].addr), wq[i].mask, wq[i].data);

        chk("loaded_during_dl", m_loaded, 0);
        nxt();
        downloading = 1'b0;
        #4;
        chk("loaded_same_cycle", m_loaded, 0);
        nxt();
        #4;
        chk("loaded_m", m_loaded, 1);
        chk("loaded_w", w_loaded, 1);
        chk("loaded_b", b_loaded, 1);

        // Main-ROM rows end on channel 2 so the arbiter pointer is back at 0
        rq.push_back('{32'd0, 32'd3,  32'h1234});
        rq.push_back('{32'd1, 32'd0,  32'hEFEF});
        rq.push_back('{32'd0, 32'd2,  32'h6666});
        rq.push_back('{32'd2, 32'd15, 32'hCAFE});
        rq.push_back('{32'd3, 32'd0,  32'hDDCCBBAA});
        rq.push_back('{32'd4, 32'd5,  32'h5A});
        rq.push_back('{32'd4, 32'd4,  32'hA5});
        rq.push_back('{32'd4, 32'd6,  32'h3C});
        rq.push_back('{32'd4, 32'd0,  32'h42});
        for (int i = 0; i < rq.size(); i++) begin
            do_read(int'(rq[i].who), int'(rq[i].addr), 1'b0, lat, d);
            chk("tbl_lat", lat, 2);
            chk("tbl_data", d, rq[i].exp);
        end

        // Three simultaneous misses are granted 0,1,2
        for (int c = 0; c < 3; c++) first[c] = -1;
        nxt();
        m_cs   = 3'b111;
        m_addr = {4'd7, 4'd6, 4'd5};
        for (int c = 0; c < 12; c++) begin
            if (c > 0) nxt();
            #4;
            for (int ch = 0; ch < 3; ch++) begin
                if (first[ch] < 0 && m_ok[ch]) begin
                    first[ch] = c;
                    fdat[ch]  = {16'h0, m_data[ch*16 +: 16]};
                end
            end
        end
        for (int ch = 0; ch < 3; ch++) begin
            chk("rr_lat", first[ch], ch + 2);
            chk("rr_data", fdat[ch], model_rd(ch, ch + 5));
        end
        nxt();
        m_cs = '0;

        // Channel 1 keeps hitting addr 5 while channel 0 misses every cycle
        do_read(1, 5, 1'b1, lat, d);
        chk("hit_first_data", d, model_rd(1, 5));
        for (int i = 0; i < 10; i++) begin
            nxt();
            m_cs[0]     = 1'b1;
            m_addr[3:0] = 4'(i);
            #4;
            chk("hit_ok", m_ok[1], 1);
            chk("hit_data", m_data[31:16], model_rd(1, 5));
        end
        nxt();
        m_cs[0]     = 1'b0;
        m_addr[7:4] = 4'd6;
        #4;
        chk("chg_ok_drop", m_ok[1], 0);
        lat = -1;
        for (int c = 1; c < 20 && lat < 0; c++) begin
            nxt();
            #4;
            if (m_ok[1]) begin lat = c; d = {16'h0, m_data[31:16]}; end
        end
        chk("chg_lat_ge2", lat >= 2, 1);
        chk("chg_data", d, model_rd(1, 6));

        // Download while channel 1 shows rd_ok, plus random programming
        nxt();
        downloading = 1'b1;
        nxt();
        #4;
        chk("dl_ok", m_ok[1], 0);
        chk("dl_loaded", m_loaded, 0);
        for (int i = 0; i < 3; i++) begin
            nxt();
            #4;
            chk("dl_ok_hold", m_ok[1], 0);
        end
        m_cs = '0;
        for (int i = 0; i < 80; i++)
            prog_wr(int'($urandom_range(0, 'h9F)), 2'($urandom_range(0, 3)), 8'($urandom));
        nxt();
        downloading = 1'b0;
        nxt();
        nxt();
        for (int i = 0; i < 30; i++) begin
            int who, addr;
            who  = int'($urandom_range(0, 4));
            addr = int'($urandom_range(0, 15));
            do_read(who, addr, 1'b0, lat, d);
            chk("rnd_done", lat >= 0, 1);
            chk("rnd_data", d, model_rd(who, addr));
        end

        // Reset while channel 0 is waiting on the RAM
        do_read(0, 1, 1'b0, lat, d);
        nxt();
        m_cs[0]     = 1'b1;
        m_addr[3:0] = 4'd2;
        nxt();
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        #4;
        chk("rstw_ok", m_ok[0], 0);
        chk("rstw_loaded", m_loaded, 0);
        nxt();
        #4;
        chk("rstw_ok_next", m_ok[0], 0);
        nxt();
        #4;
        chk("rstw_refetch_ok", m_ok[0], 1);
        chk("rstw_refetch_data", m_data[15:0], model_rd(0, 2));
        nxt();
        m_cs = '0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/jtframe_bram_rom_mc.md
Name: jtframe_bram_rom_mc

Overview:
- Multi-channel ROM held in block RAM. It is loaded through the same byte-wide programming bus that drives the SDRAM during download.
- CH independent read channels use the cs/ok handshake of the SDRAM ROM slots. They share one BRAM read port through a round-robin arbiter, and each channel keeps a one-entry address cache.
- Sits between jtframe_dwnld and core logic (tile/sprite/sound ROM clients) that would otherwise take SDRAM slots.

Parameters:
- DW, 16, data width per channel: 8, 16 or 32; any other value is a elaboration error.
- AW, 10, read address width in DW-sized words.
- CH, 2, number of read channels (1..8).
- PW, 25 if JTFRAME_SDRAM_LARGE else 24, programming address width (16-bit word address).
- OFFSET, 0, first prog_addr (16-bit words) belonging to this ROM.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- downloading  in  1  high while jtframe_dwnld is loading.
- rd_cs  in  CH  per-channel request.
- rd_addr  in  CH*AW  channel n at bits [n*AW+:AW].
- rd_ok  out  CH  data valid for the current rd_addr.
- rd_data  out  CH*DW  channel n at bits [n*DW+:DW].
- prog_addr  in  PW  16-bit word address.
- prog_mask  in  2  active-low byte-lane select (bit0 low = low byte).
- prog_data  in  8  byte to write.
- prog_we  in  1  write strobe.
- loaded  out  1  content valid (set on the downloading falling edge).

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: rd_ok=0, rd_data=0, loaded=0, all cache-valid bits=0, arbiter pointer=0.
- Write side:
  - Range is OFFSET <= prog_addr < OFFSET+WORDS, with WORDS = 2^(AW-1) for DW=8, 2^AW for DW=16, 2^(AW+1) for DW=32.
  - aeff = prog_addr-OFFSET. Out-of-range writes are ignored.
  - DW=8: byte address {aeff[AW-2:0], lane}, where lane=0 when prog_mask[0]=0, else 1.
  - DW=16: word aeff[AW-1:0]; byte enable = ~prog_mask.
  - DW=32: word aeff[AW:1]; byte enables {~prog_mask & {2{aeff[0]}}, ~prog_mask & {2{~aeff[0]}}}, so aeff[0]=0 writes the low half.
  - prog_mask=2'b11 writes nothing.
- Read side: BRAM read latency is 1 cycle.
- Per-channel state machine:
  - IDLE -> REQ when rd_cs=1 and (!valid or rd_addr != cached addr).
  - REQ -> WAIT when granted; the address is latched at grant.
  - WAIT -> IDLE on the next cycle. Data is stored in the channel's rd_data and valid is set.
- Hit: rd_cs=1 with valid and rd_addr equal to the cached address gives rd_ok=1 combinationally from registered state, with no BRAM access.
- Best-case miss latency: request cycle 0, grant cycle 0, data registered end of cycle 1, rd_ok=1 in cycle 2.
- Address change with rd_cs held high: rd_ok drops in the same cycle (the comparison fails) and a new fetch starts. If the address changes while in WAIT, the returned data is still cached for the latched address, then re-requested.
- rd_cs=0 forces rd_ok=0 but keeps the cache.
- Arbiter:
  - Rotating priority; one grant per cycle.
  - After granting channel n, the highest priority goes to n+1 mod CH.
  - Simultaneous requests are served in rotation. Maximum wait for a requesting channel is CH cycles.
- Download:
  - While downloading=1, all valid bits clear every cycle, rd_ok=0, grants are suppressed and loaded=0.
  - loaded is set the cycle after downloading falls and stays set until rst or the next download.
  - A read and a write to the same word in the same cycle return old data. This cannot happen in practice because reads are blocked during download.
- Reset mid-fetch: the pending WAIT is discarded, valid=0 and rd_ok=0 the next cycle.

Decomposition:
- Shared package (jtframe_rom_pkg): lane-mapping function for DW 8/16/32 and a localparam function WORDS(DW,AW). No typedefs needed.
- Sub-module jtframe_bram_bewr: simple dual-port RAM with one registered read port and one write port with DW/8 byte enables. Instantiated once.
- Arbiter and channel FSMs stay in the top module via generate loops.

Test Plan:
- Load DW=16, AW=4, OFFSET=0x10: write 0x34 (mask 2'b10) and 0x12 (mask 2'b01) at prog_addr 0x13, then drop downloading -> loaded=1 one cycle later; channel 0 reads addr 3 -> rd_ok=1 two cycles after rd_cs, data 0x1234.
- Writes at prog_addr 0x0F and 0x20 with OFFSET=0x10, AW=4 -> RAM unchanged; reads return the prior content.
- CH=3: all rd_cs rise together on distinct addresses -> grants in order 0,1,2; rd_ok at cycles 2,3,4.
- Cache hit: channel 1 holds addr 5 after ok, another channel reads heavily -> channel 1 rd_ok stays high with no grant to channel 1; change its addr to 6 -> rd_ok low that cycle, high again two or more cycles later with the new data.
- DW=32: writes at aeff 0 (0xBBAA) and aeff 1 (0xDDCC) -> word 0 reads 0xDDCCBBAA; DW=8 at aeff 2, mask 2'b01 -> byte address 5.
- Raise downloading while rd_ok=1 -> rd_ok=0 next cycle and stays 0 until download ends; rst mid-WAIT -> rd_ok=0 and loaded=0.
